// File: rtl/sd_uart_pkg.sv
// Shared definitions for the SD-card serial path: parity modes, FSM encoding, baud divisor.
// Latency: n/a (constants, types and an elaboration-time helper only).
// Backpressure: n/a.
package sd_uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per line bit; integer truncation is intended.
    function automatic int baud_div(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/sd_uart_tx_fifo_if.sv
// Word-in / serial-out bundle of the UART transmitter with its status outputs.
// Latency: n/a (wiring only).
// Backpressure: pi_valid/pi_ready handshake; a word moves on an edge where both are high.
interface sd_uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] pi_data;
    logic                 pi_valid;
    logic                 pi_ready;
    logic                 tx;
    logic                 busy;
    logic [LVL_W-1:0]     fifo_level;

    // Producer side (SD read-back logic, or a bench).
    modport master (
        output pi_data, pi_valid,
        input  pi_ready, tx, busy, fifo_level
    );

    // Transmitter side.
    modport slave (
        input  pi_data, pi_valid,
        output pi_ready, tx, busy, fifo_level
    );
endinterface

// File: rtl/sd_sync_fifo.sv
// Generic single-clock FIFO with full/empty/level status and a combinational head word.
// Latency: a word pushed on edge N is visible at head_o after edge N (one cycle to pop).
// Backpressure: push ignored when full (even with a simultaneous pop), pop ignored when empty.
module sd_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sd_sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Full blocks a push even when a pop happens in the same cycle: no bypass.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy next state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/sd_uart_tx_fifo.sv
// UART transmitter fed by a FIFO: LSB-first frames, optional parity, 1 or 2 stop bits, back-to-back.
// Latency: word written on edge N into an empty idle block drives the start bit from edge N+1.
// Backpressure: pi_ready = FIFO not full; frames then drain at line rate with no idle gap.
module sd_uart_tx_fifo
    import sd_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 20_000_000,
    parameter int UART_BPS   = 921600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    sd_uart_tx_fifo_if.slave     bus
);

    localparam int DIV   = baud_div(CLK_FREQ, UART_BPS);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "sd_uart_tx_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $fatal(1, "sd_uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $fatal(1, "sd_uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
        $fatal(1, "sd_uart_tx_fifo: CLK_FREQ/UART_BPS must be at least 2");
    end

    uart_state_t          state_q;
    logic [CNT_W-1:0]     baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 tx_q;

    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LVL_W-1:0]     fifo_level;
    logic                 fifo_pop;
    logic                 head_par;
    logic                 baud_end;
    logic                 stop_end;

    sd_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .push_i     (bus.pi_valid),
        .push_dat_i (bus.pi_data),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    assign baud_end = (baud_q == DIV_LAST);
    assign stop_end = (state_q == ST_STOP) && baud_end && (bit_q == STOP_LAST);

    // The head is taken from idle, or on the last stop cycle so the next start bit follows directly.
    assign fifo_pop = !fifo_empty && ((state_q == ST_IDLE) || stop_end);

    // Parity is fixed when the word leaves the FIFO, so later writes cannot disturb the frame.
    assign head_par = (PARITY == PAR_ODD) ? ~(^fifo_head) : (^fifo_head);

    assign bus.pi_ready   = !fifo_full;
    assign bus.tx         = tx_q;
    assign bus.fifo_level = fifo_level;
    assign bus.busy       = (state_q != ST_IDLE) || (fifo_level != '0);

    // Frame sequencer: every bit lasts DIV cycles, tx is registered, and reset drops any frame in flight.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (!fifo_empty) begin
                        shift_q <= fifo_head;
                        par_q   <= head_par;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == DATA_LAST) begin
                            bit_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= par_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == STOP_LAST) begin
                            bit_q <= '0;
                            if (!fifo_empty) begin
                                shift_q <= fifo_head;
                                par_q   <= head_par;
                                tx_q    <= 1'b0;
                                state_q <= ST_START;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_uart_tx_fifo.sv
// Bench for sd_uart_tx_fifo: four instances (8N1, 8E1, 7O2, 8N1 with its own reset).
// Stimulus pushes expected frames (word + predicted start edge) into per-instance queues;
// per-instance monitors capture whole frames off tx and compare them against the queues.
module tb_sd_uart_tx_fifo;

    localparam int DIV = 20_000_000 / 921600;
    localparam int DBK  [4] = '{8, 8, 7, 8};
    localparam int PARK [4] = '{0, 2, 1, 0};
    localparam int SBK  [4] = '{1, 1, 2, 1};

    typedef struct {
        logic [8:0] data;
        int         start;
    } exp_t;

    logic clk = 1'b0;
    logic rst_abc = 1'b1;
    logic rst_d = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t exp_q [4][$];
    int   prev_end [4];

    sd_uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if0 ();
    sd_uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if1 ();
    sd_uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) if2 ();
    sd_uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if3 ();

    sd_uart_tx_fifo u0 (.sys_clk(clk), .sys_rst(rst_abc), .bus(if0.slave));
    sd_uart_tx_fifo #(.PARITY(2)) u1 (.sys_clk(clk), .sys_rst(rst_abc), .bus(if1.slave));
    sd_uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (.sys_clk(clk), .sys_rst(rst_abc), .bus(if2.slave));
    sd_uart_tx_fifo u3 (.sys_clk(clk), .sys_rst(rst_d), .bus(if3.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int flen(input int k);
        return DIV * (1 + DBK[k] + ((PARK[k] != 0) ? 1 : 0) + SBK[k]);
    endfunction

    function automatic logic [8:0] dmask(input int k);
        return 9'((1 << DBK[k]) - 1);
    endfunction

    // Even mode sends 1 when the count of ones is odd; odd mode sends the complement.
    function automatic logic exp_par(input int k, input logic [8:0] d);
        int ones;
        ones = $countones(d & dmask(k));
        return (PARK[k] == 2) ? logic'(ones % 2) : logic'(1 - (ones % 2));
    endfunction

    // Level the line should hold at cycle j of a frame carrying d.
    function automatic logic exp_level(input int k, input logic [8:0] d, input int j);
        int b;
        b = j / DIV;
        if (b == 0) return 1'b0;
        if (b <= DBK[k]) return d[b-1];
        if (PARK[k] != 0 && b == DBK[k] + 1) return exp_par(k, d);
        return 1'b1;
    endfunction

    function automatic logic tx_of(input int k);
        case (k)
            0: return if0.tx;
            1: return if1.tx;
            2: return if2.tx;
            default: return if3.tx;
        endcase
    endfunction

    function automatic logic busy_of(input int k);
        case (k)
            0: return if0.busy;
            1: return if1.busy;
            2: return if2.busy;
            default: return if3.busy;
        endcase
    endfunction

    function automatic logic rdy_of(input int k);
        case (k)
            0: return if0.pi_ready;
            1: return if1.pi_ready;
            2: return if2.pi_ready;
            default: return if3.pi_ready;
        endcase
    endfunction

    function automatic logic [4:0] lvl_of(input int k);
        case (k)
            0: return if0.fifo_level;
            1: return if1.fifo_level;
            2: return if2.fifo_level;
            default: return if3.fifo_level;
        endcase
    endfunction

    function automatic logic rst_of(input int k);
        return (k == 3) ? rst_d : rst_abc;
    endfunction

    task automatic set_in(input int k, input logic v, input logic [8:0] d);
        case (k)
            0: begin if0.pi_valid = v; if0.pi_data = d[7:0]; end
            1: begin if1.pi_valid = v; if1.pi_data = d[7:0]; end
            2: begin if2.pi_valid = v; if2.pi_data = d[6:0]; end
            default: begin if3.pi_valid = v; if3.pi_data = d[7:0]; end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: a frame starts one edge after its word is accepted, but never before the previous frame ends.
    task automatic model_push(input int k, input logic [8:0] d, input int acc_edge, output int start);
        exp_t e;
        start = (acc_edge + 1 > prev_end[k]) ? acc_edge + 1 : prev_end[k];
        prev_end[k] = start + flen(k);
        e.data = d;
        e.start = start;
        exp_q[k].push_back(e);
    endtask

    // Called just after a negedge; offers d until accepted, returns at the negedge after the accepting edge.
    task automatic send(input int k, input logic [8:0] din, input bit hold, output int start);
        int n;
        logic [8:0] d;
        d = din & dmask(k);
        n = 0;
        start = -1;
        set_in(k, 1'b1, d);
        while (!rdy_of(k) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept_%0d", k), rdy_of(k), 1);
        if (rdy_of(k)) begin
            model_push(k, d, cyc + 1, start);
            @(negedge clk);
        end
        if (!hold) set_in(k, 1'b0, d);
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((exp_q[k].size() != 0 || busy_of(k)) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("drain_q_%0d", k), exp_q[k].size(), 0);
        chk($sformatf("drain_busy_%0d", k), busy_of(k), 0);
    endtask

    // Captures every frame on tx and checks start time, payload, parity and the full waveform.
    task automatic monitor(input int k);
        logic       smp [300];
        int         s, len, db, nbad;
        bit         aborted;
        exp_t       e;
        logic [8:0] obs;
        len = flen(k);
        db = DBK[k];
        forever begin
            @(negedge clk);
            if (rst_of(k) || tx_of(k) !== 1'b0) continue;
            s = cyc;
            smp[0] = 1'b0;
            aborted = 1'b0;
            for (int j = 1; j < len; j++) begin
                @(negedge clk);
                if (rst_of(k)) begin
                    aborted = 1'b1;
                    break;
                end
                smp[j] = tx_of(k);
            end
            if (aborted) continue;
            if (exp_q[k].size() == 0) begin
                chk($sformatf("unexpected_frame_%0d", k), 1, 0);
                continue;
            end
            e = exp_q[k].pop_front();
            chk($sformatf("start_edge_%0d", k), s, e.start);
            obs = '0;
            for (int i = 0; i < db; i++) obs[i] = smp[(1 + i) * DIV + DIV / 2];
            chk($sformatf("data_%0d", k), obs, e.data);
            if (PARK[k] != 0)
                chk($sformatf("parity_%0d", k), smp[(1 + db) * DIV + DIV / 2], exp_par(k, e.data));
            nbad = 0;
            for (int j = 0; j < len; j++) if (smp[j] !== exp_level(k, e.data, j)) nbad++;
            chk($sformatf("wave_%0d", k), nbad, 0);
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none
    end

    initial begin
        #700_000;
        $display("FAIL watchdog cycle=%0d checks=%0d errors=%0d", cyc, checks, errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            set_in(k, 1'b0, 9'h000);
            prev_end[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_tx_%0d", k), tx_of(k), 1);
            chk($sformatf("rst_busy_%0d", k), busy_of(k), 0);
            chk($sformatf("rst_ready_%0d", k), rdy_of(k), 1);
            chk($sformatf("rst_level_%0d", k), lvl_of(k), 0);
        end
        rst_abc = 1'b0;
        rst_d = 1'b0;
        @(negedge clk);

        fork
            begin : run_a
                int s;
                int s2;
                send(0, 9'h055, 0, s);
                while (cyc < s + flen(0) - 1) @(negedge clk);
                chk("a_busy_last_stop", busy_of(0), 1);
                @(negedge clk);
                chk("a_busy_after_stop", busy_of(0), 0);
                chk("a_tx_idle", tx_of(0), 1);
                drain(0);
                for (int i = 0; i < 17; i++) send(0, 9'($urandom_range(0, 255)), 1, s);
                chk("a_burst_level", lvl_of(0), 16);
                chk("a_burst_ready", rdy_of(0), 0);
                set_in(0, 1'b0, 9'h000);
                drain(0);
                send(0, 9'($urandom_range(0, 255)), 0, s);
                while (cyc < s + flen(0) - 2) @(negedge clk);
                send(0, 9'($urandom_range(0, 255)), 0, s2);
                drain(0);
                send(0, 9'($urandom_range(0, 255)), 0, s);
                while (cyc < s + flen(0) - 1) @(negedge clk);
                send(0, 9'($urandom_range(0, 255)), 0, s2);
                drain(0);
            end
            begin : run_b
                int s;
                send(1, 9'h007, 0, s);
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 250)) @(negedge clk);
                    send(1, 9'($urandom_range(0, 255)), 0, s);
                end
                drain(1);
            end
            begin : run_c
                int s;
                send(2, 9'h041, 0, s);
                send(2, 9'h007, 0, s);
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(0, 250)) @(negedge clk);
                    send(2, 9'($urandom_range(0, 127)), 0, s);
                end
                drain(2);
            end
            begin : run_d
                int s0;
                int s;
                send(3, 9'h0F0, 1, s0);
                send(3, 9'h0AA, 1, s);
                send(3, 9'h033, 0, s);
                while (cyc < s0 + DIV * 4 + 10) @(negedge clk);
                chk("d_pre_rst_tx", tx_of(3), 0);
                chk("d_pre_rst_level", lvl_of(3), 2);
                rst_d = 1'b1;
                #1;
                chk("d_rst_tx", tx_of(3), 1);
                chk("d_rst_level", lvl_of(3), 0);
                chk("d_rst_ready", rdy_of(3), 1);
                chk("d_rst_busy", busy_of(3), 0);
                repeat (2) @(negedge clk);
                rst_d = 1'b0;
                exp_q[3].delete();
                prev_end[3] = 0;
                @(negedge clk);
                send(3, 9'h0A5, 0, s);
                drain(3);
            end
        join

        for (int k = 0; k < 4; k++) chk($sformatf("end_tx_%0d", k), tx_of(k), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_uart_tx_fifo.md
Name: sd_uart_tx_fifo

Overview:
Parametrised UART transmitter, the next generation of the SD-card logging serial path. Configurable data width, parity mode and stop-bit count. A ready/valid input handshake feeds an internal FIFO, so the SD read-back logic can burst bytes without pacing itself to the baud rate. Frames are sent back-to-back, LSB first, with no idle gap while the FIFO holds data.

Parameters:
CLK_FREQ, 20_000_000, system clock frequency in Hz
UART_BPS, 921600, line baud rate
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; 1 or 2
FIFO_DEPTH, 16, FIFO entries; power of 2, at least 2

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-high reset
pi_data  in  DATA_BITS  word to transmit
pi_valid  in  1  pi_data valid
pi_ready  out  1  FIFO can accept a word; equals not-full
tx  out  1  serial line, idle high, registered
busy  out  1  high while a frame is on the line or the FIFO is non-empty
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is asynchronous and active-high on sys_clk; there is one clock domain.
- Reset values: tx=1, busy=0, pi_ready=1, fifo_level=0, FIFO empty, FSM in IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame: tx returns to 1 immediately and FIFO contents are discarded.
- Baud divisor: DIV = CLK_FREQ/UART_BPS, integer truncation; 21 at the default parameters.
- Every bit, including start, parity and stop bits, lasts exactly DIV cycles.
- Frame length = DIV*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- Write rule: a word is written on any rising edge where pi_valid && pi_ready. pi_ready is combinational from the occupancy count.
- Full FIFO: pi_ready is low even if a pop happens in the same cycle. No bypass path exists.
- Simultaneous push and pop when the FIFO is not full: occupancy is unchanged.
- The FIFO is never overwritten. Words are popped in write order.
- Pointers are clog2(FIFO_DEPTH) bits wide and wrap naturally at depth.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, compute parity, set tx=0 and go to START.
  - START: after DIV cycles, go to DATA; tx = shift[0].
  - DATA: shift right every DIV cycles. After DATA_BITS bits, go to PARITY if PARITY!=0, otherwise go to STOP.
  - PARITY: even mode sends XOR of the data bits; odd mode sends its inverse. Lasts DIV cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*DIV cycles. On the last cycle, if the FIFO is non-empty, pop and drive tx=0 on the next edge (stay in START path, no IDLE cycle). Otherwise go to IDLE.
- Latency: a word written at edge N into an empty FIFO with the FSM in IDLE gives tx=0 from edge N+1.
- Parity is computed from the popped word at pop time. Later FIFO writes do not affect the frame in flight.
- Baud counter: ceil(log2(DIV)) bits. It is cleared in IDLE and at every bit boundary.
- busy = (state != IDLE) || (fifo_level != 0).
- Illegal parameter values (DATA_BITS outside 5..9, PARITY>2, STOP_BITS not 1 or 2, DIV<2) are caught by elaboration-time checks that stop simulation.

Decomposition:
- Shared package sd_uart_pkg holds:
  - the parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN
  - the FSM state encoding
  - a divisor function that computes CLK_FREQ/UART_BPS
- One sub-module: sd_sync_fifo, a parametrised width/depth synchronous FIFO with full, empty and level outputs. It will be reused later by the SD receive path.

Test Plan:
- Defaults (DIV=21, 8N1), write 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1, each level held 21 cycles; frame 210 cycles; busy falls right after the stop bit.
- PARITY=2 (even), write 0x07 -> parity bit 1; PARITY=1 (odd), write 0x07 -> parity bit 0; frame 231 cycles.
- DATA_BITS=7, STOP_BITS=2, write 0x41 -> 7 data bits 1,0,0,0,0,0,1, then tx=1 for 42 cycles; frame 231 cycles.
- Burst of 17 words with pi_valid held high, FIFO_DEPTH=16 -> pi_ready drops when fifo_level reaches 16 (the FSM pops the first word, so all 17 are accepted); frames are contiguous with no idle gap; all bytes arrive in order.
- Assert sys_rst during data bit 3 -> tx=1 immediately; fifo_level=0; pi_ready=1; a new word after release transmits cleanly.
- Write arriving on the final stop-bit cycle of the previous frame -> next start bit begins on the following edge (no extra idle cycle).
